// File: rtl/risc_dbg_pkg.sv
// Shared definitions for the Risc32 run-control sequencer: command codes,
// FSM state encoding and default widths.
package risc_dbg_pkg;

    localparam int PC_W_DEF  = 32;
    localparam int CNT_W_DEF = 16;
    localparam int RET_W_DEF = 32;

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_HALT    = 3'd1;
    localparam logic [2:0] CMD_RUN     = 3'd2;
    localparam logic [2:0] CMD_STEP    = 3'd3;
    localparam logic [2:0] CMD_RUN_N   = 3'd4;
    localparam logic [2:0] CMD_SET_BP  = 3'd5;
    localparam logic [2:0] CMD_CLR_BP  = 3'd6;
    localparam logic [2:0] CMD_CLR_CNT = 3'd7;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_COUNT  = 2'd2
    } dbg_state_t;

endpackage

// File: rtl/risc_debug_ctrl.sv
// Run-control sequencer: gates the single-cycle core with cpu_en and provides
// halt / run / step / run-N, one PC breakpoint and a retired-instruction count.
module risc_debug_ctrl
    import risc_dbg_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int RET_W = RET_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic [PC_W-1:0]  cpu_pc,
    output logic             cpu_en,
    output logic             halted,
    output logic             done,
    output logic             bp_hit,
    output logic             cmd_err,
    output logic [RET_W-1:0] retired
);

    dbg_state_t       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             skip_reg, skip_next;
    logic             bp_en_reg, bp_en_next;
    logic [PC_W-1:0]  bp_addr_reg, bp_addr_next;
    logic             bp_hit_reg, bp_hit_next;
    logic             done_reg, done_next;
    logic             cmd_err_reg, cmd_err_next;
    logic [RET_W-1:0] retired_reg, retired_next;

    logic accept;
    logic bp_match;
    logic bp_stop;
    logic running;

    assign cmd_ready = !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign running   = (state_reg != ST_HALTED);
    assign bp_match  = bp_en_reg && (cpu_pc == bp_addr_reg);
    // skip lets a resumed run commit the instruction it stopped on
    assign bp_stop   = running && bp_match && !skip_reg;
    assign cpu_en    = !rst && running && !bp_stop;

    assign halted  = (state_reg == ST_HALTED);
    assign done    = done_reg;
    assign bp_hit  = bp_hit_reg;
    assign cmd_err = cmd_err_reg;
    assign retired = retired_reg;

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        skip_next    = skip_reg;
        bp_en_next   = bp_en_reg;
        bp_addr_next = bp_addr_reg;
        bp_hit_next  = bp_hit_reg;
        done_next    = 1'b0;
        cmd_err_next = 1'b0;
        retired_next = retired_reg;

        if (cpu_en) begin
            skip_next    = 1'b0;
            retired_next = retired_reg + RET_W'(1);
            if (state_reg == ST_COUNT) begin
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    state_next = ST_HALTED;
                    done_next  = 1'b1;
                end
            end
        end

        if (bp_stop) begin
            state_next  = ST_HALTED;
            bp_hit_next = 1'b1;
        end

        if (accept) begin
            case (cmd_op)
                CMD_HALT: state_next = ST_HALTED;
                CMD_RUN, CMD_STEP, CMD_RUN_N: begin
                    if (state_reg == ST_HALTED) begin
                        skip_next   = 1'b1;
                        bp_hit_next = 1'b0;
                        if (cmd_op == CMD_RUN) begin
                            state_next = ST_RUN;
                        end else if (cmd_op == CMD_STEP) begin
                            state_next = ST_COUNT;
                            count_next = CNT_W'(1);
                        end else if (cmd_arg != '0) begin
                            state_next = ST_COUNT;
                            count_next = cmd_arg;
                        end else begin
                            done_next = 1'b1;
                        end
                    end else begin
                        cmd_err_next = 1'b1;
                    end
                end
                CMD_SET_BP: begin
                    bp_addr_next = PC_W'(cmd_arg);
                    bp_en_next   = 1'b1;
                end
                CMD_CLR_BP:  bp_en_next   = 1'b0;
                CMD_CLR_CNT: retired_next = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_HALTED;
            count_reg   <= '0;
            skip_reg    <= 1'b0;
            bp_en_reg   <= 1'b0;
            bp_addr_reg <= '0;
            bp_hit_reg  <= 1'b0;
            done_reg    <= 1'b0;
            cmd_err_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            skip_reg    <= skip_next;
            bp_en_reg   <= bp_en_next;
            bp_addr_reg <= bp_addr_next;
            bp_hit_reg  <= bp_hit_next;
            done_reg    <= done_next;
            cmd_err_reg <= cmd_err_next;
            retired_reg <= retired_next;
        end
    end

endmodule

// File: tb/tb_risc_debug_ctrl.sv
// Scoreboard bench for risc_debug_ctrl: stimulus pushes expected done / error /
// halt events, a negedge monitor pops and compares them as the DUT raises them.
module tb_risc_debug_ctrl;
    import risc_dbg_pkg::*;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;
    localparam int RET_W = 32;

    localparam logic [1:0] EV_DONE = 2'd0;
    localparam logic [1:0] EV_ERR  = 2'd1;
    localparam logic [1:0] EV_HALT = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] retired;
        logic [31:0] pc;
        logic        bp_hit;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;
    logic [PC_W-1:0]  cpu_pc;
    logic             cpu_en;
    logic             halted;
    logic             done;
    logic             bp_hit;
    logic             cmd_err;
    logic [RET_W-1:0] retired;

    logic             pc_load;
    logic [PC_W-1:0]  pc_load_val;
    logic             rst_q = 1'b1;
    logic             prev_halted = 1'b1;

    ev_t sb[$];
    int  n_checks   = 0;
    int  n_fail     = 0;
    int  en_cycles  = 0;

    risc_debug_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .RET_W(RET_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cpu_pc    (cpu_pc),
        .cpu_en    (cpu_en),
        .halted    (halted),
        .done      (done),
        .bp_hit    (bp_hit),
        .cmd_err   (cmd_err),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Core model: pc advances by one on every committed instruction
    always @(posedge clk) begin
        rst_q <= rst;
        if (pc_load) cpu_pc <= pc_load_val;
        else if (cpu_en === 1'b1) cpu_pc <= cpu_pc + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pop_compare(input logic [1:0] kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = sb.pop_front();
            $display("[%0t] event kind=%0d retired=%0d pc=%0d bp_hit=%0b halted=%0b",
                     $time, kind, retired, cpu_pc, bp_hit, halted);
            check("event_kind", 32'(kind), 32'(e.kind));
            if (e.kind == EV_ERR) begin
                check("err_still_running", 32'(halted), 32'd0);
            end else begin
                check("event_retired", retired, e.retired);
                check("event_pc", cpu_pc, e.pc);
                check("event_bp_hit", 32'(bp_hit), 32'(e.bp_hit));
                check("event_halted", 32'(halted), 32'd1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (cpu_en === 1'b1) en_cycles++;
        if (rst === 1'b0 && rst_q === 1'b0) begin
            if (done === 1'b1) pop_compare(EV_DONE);
            else if (cmd_err === 1'b1) pop_compare(EV_ERR);
            else if (halted === 1'b1 && prev_halted === 1'b0) pop_compare(EV_HALT);
        end
        prev_halted = halted;
    end

    task automatic expect_ev(input logic [1:0] kind, input logic [31:0] ret,
                             input logic [31:0] pc, input logic bph);
        ev_t e;
        e.kind = kind; e.retired = ret; e.pc = pc; e.bp_hit = bph;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] arg);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = CMD_NOP; cmd_arg = '0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        @(posedge clk); #1;
        pc_load = 1'b1; pc_load_val = v;
        @(posedge clk); #1;
        pc_load = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending events expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = CMD_NOP; cmd_arg = '0;
        pc_load = 1'b1; pc_load_val = 32'd0;
        idle(3); #1;
        rst = 1'b0; pc_load = 1'b0;

        // 1: reset state after idling
        idle(5); #1;
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);

        // 2: single step from pc 0
        en_cycles = 0;
        expect_ev(EV_DONE, 32'd1, 32'd1, 1'b0);
        issue(CMD_STEP, 16'd0);
        wait_drain(50);
        check("step_en_cycles", 32'(en_cycles), 32'd1);
        @(negedge clk);
        check("step_done_one_cycle", 32'(done), 32'd0);

        // 3: breakpoint at 12, then step over it
        set_pc(32'd0);
        issue(CMD_CLR_CNT, 16'd0);
        issue(CMD_SET_BP, 16'd12);
        en_cycles = 0;
        expect_ev(EV_HALT, 32'd12, 32'd12, 1'b1);
        issue(CMD_RUN, 16'd0);
        wait_drain(100);
        check("bp_en_cycles", 32'(en_cycles), 32'd12);
        check("bp_cpu_en_low", 32'(cpu_en), 32'd0);
        expect_ev(EV_DONE, 32'd13, 32'd13, 1'b0);
        issue(CMD_STEP, 16'd0);
        wait_drain(50);

        // 4: RUN_N 3, then RUN_N 0
        issue(CMD_CLR_BP, 16'd0);
        en_cycles = 0;
        expect_ev(EV_DONE, 32'd16, 32'd16, 1'b0);
        issue(CMD_RUN_N, 16'd3);
        wait_drain(50);
        check("runn3_en_cycles", 32'(en_cycles), 32'd3);
        en_cycles = 0;
        expect_ev(EV_DONE, 32'd16, 32'd16, 1'b0);
        issue(CMD_RUN_N, 16'd0);
        wait_drain(50);
        check("runn0_en_cycles", 32'(en_cycles), 32'd0);

        // 5: STEP while running is an error; HALT commits its accept cycle
        en_cycles = 0;
        issue(CMD_RUN, 16'd0);
        idle(2);
        expect_ev(EV_ERR, 32'd0, 32'd0, 1'b0);
        issue(CMD_STEP, 16'd0);
        expect_ev(EV_HALT, 32'd22, 32'd22, 1'b0);
        issue(CMD_HALT, 16'd0);
        wait_drain(50);
        check("halt_en_cycles", 32'(en_cycles), 32'd6);

        // 6: breakpoint halt with retired 40, then reset clears everything
        set_pc(32'hFFFF_FFFA);
        issue(CMD_SET_BP, 16'd12);
        en_cycles = 0;
        expect_ev(EV_HALT, 32'd40, 32'd12, 1'b1);
        issue(CMD_RUN, 16'd0);
        wait_drain(100);
        check("bp2_en_cycles", 32'(en_cycles), 32'd18);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst2_halted", 32'(halted), 32'd1);
        check("rst2_bp_hit", 32'(bp_hit), 32'd0);
        check("rst2_retired", retired, 32'd0);
        set_pc(32'd10);
        expect_ev(EV_HALT, 32'd5, 32'd15, 1'b0);
        issue(CMD_RUN, 16'd0);
        idle(3);
        issue(CMD_HALT, 16'd0);
        wait_drain(50);

        // reset asserted while running forces cpu_en low
        issue(CMD_RUN, 16'd0);
        idle(2);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_run_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_run_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        check("rst3_halted", 32'(halted), 32'd1);
        check("rst3_retired", retired, 32'd0);
        idle(3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
